// File: rtl/matrix_load_ctrl.sv
// Matrix load sequencer: collects N_ELEM serial elements over a valid/ready
// handshake into a row-major staging word, then issues a one-cycle load
// command to the matrix memory and pulses done once the memory holds it.
module matrix_load_ctrl #(
    parameter int ELEM_W = 21,
    parameter int N_ELEM = 16,
    parameter int CNT_W  = 5
) (
    input  logic                       CLK,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       abort,
    input  logic [ELEM_W-1:0]          elem_in,
    input  logic                       elem_valid,
    output logic                       elem_ready,
    output logic [ELEM_W*N_ELEM-1:0]   Min,
    output logic                       memory_state,
    output logic                       busy,
    output logic                       done,
    output logic [CNT_W-1:0]           elem_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t                     state_r;
    state_t                     state_s;
    logic [ELEM_W*N_ELEM-1:0]   min_r;
    logic [ELEM_W*N_ELEM-1:0]   min_s;
    logic [CNT_W-1:0]           count_r;
    logic [CNT_W-1:0]           count_s;
    logic                       done_r;
    logic                       last_s;
    logic                       elem_ready_s;
    logic                       memory_state_s;
    logic                       busy_s;

    // The element being accepted now is the final one of the matrix
    assign last_s = (count_r == CNT_W'(N_ELEM - 1));

    // State register
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode; abort outranks an element offered in the same cycle
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = FILL;
                end else begin
                    state_s = IDLE;
                end
            end
            FILL: begin
                if (abort) begin
                    state_s = IDLE;
                end else if (elem_valid && last_s) begin
                    state_s = COMMIT;
                end else begin
                    state_s = FILL;
                end
            end
            COMMIT: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Output decode of the registered state
    always_comb begin
        elem_ready_s   = 1'b0;
        memory_state_s = 1'b0;
        busy_s         = 1'b0;
        case (state_r)
            IDLE: begin
                busy_s = 1'b0;
            end
            FILL: begin
                elem_ready_s = 1'b1;
                busy_s       = 1'b1;
            end
            COMMIT: begin
                memory_state_s = 1'b1;
                busy_s         = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    // Staging word and element counter next values; Min keeps partial data on abort
    always_comb begin
        min_s   = min_r;
        count_s = count_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    min_s   = '0;
                    count_s = '0;
                end else begin
                    count_s = count_r;
                end
            end
            FILL: begin
                if (abort) begin
                    count_s = '0;
                end else if (elem_valid) begin
                    for (int i = 0; i < N_ELEM; i++) begin
                        if (count_r == CNT_W'(i)) begin
                            min_s[i*ELEM_W +: ELEM_W] = elem_in;
                        end else begin
                            min_s[i*ELEM_W +: ELEM_W] = min_r[i*ELEM_W +: ELEM_W];
                        end
                    end
                    count_s = count_r + CNT_W'(1);
                end else begin
                    count_s = count_r;
                end
            end
            default: begin
                count_s = count_r;
            end
        endcase
    end

    // Datapath registers; done marks the first cycle the memory holds the matrix
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            min_r   <= '0;
            count_r <= '0;
            done_r  <= 1'b0;
        end else begin
            min_r   <= min_s;
            count_r <= count_s;
            done_r  <= (state_r == COMMIT);
        end
    end

    assign elem_ready   = elem_ready_s;
    assign memory_state = memory_state_s;
    assign busy         = busy_s;
    assign Min          = min_r;
    assign elem_count   = count_r;
    assign done         = done_r;

endmodule

// File: tb/tb_matrix_load_ctrl.sv
// Directed bench for matrix_load_ctrl: fills, backpressure, abort,
// ignored controls, back-to-back matrices and asynchronous reset.
module tb_matrix_load_ctrl;

    logic          CLK;
    logic          reset;
    logic          start;
    logic          abort;
    logic [20:0]   elem_in;
    logic          elem_valid;
    logic          elem_ready;
    logic [335:0]  Min;
    logic          memory_state;
    logic          busy;
    logic          done;
    logic [4:0]    elem_count;

    int            n_checks;
    int            n_fail;
    int            cyc;
    int            t1;
    int            pulses;
    int            acc;
    logic [335:0]  exp_min;

    matrix_load_ctrl dut (
        .CLK          (CLK),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .elem_in      (elem_in),
        .elem_valid   (elem_valid),
        .elem_ready   (elem_ready),
        .Min          (Min),
        .memory_state (memory_state),
        .busy         (busy),
        .done         (done),
        .elem_count   (elem_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [335:0] obs, input logic [335:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    function automatic logic [20:0] elem_val(input int mode, input int k);
        logic [20:0] v;
        case (mode)
            0:       v = 21'(k + 1);
            1:       v = 21'h0F0000 ^ 21'(k);
            2:       v = 21'(k * 3 + 7);
            default: v = 21'h01F0F0 ^ 21'(k);
        endcase
        return v;
    endfunction

    // Drives 16 back-to-back elements (already in FILL); ends in COMMIT cycle
    task automatic run_fill(input int mode, output logic [335:0] expv);
        expv = '0;
        for (int k = 0; k < 16; k++) begin
            elem_valid = 1'b1;
            elem_in    = elem_val(mode, k);
            start      = (mode == 1 && k == 3) ? 1'b1 : 1'b0;
            expv[k*21 +: 21] = elem_val(mode, k);
            step();
            chk("fill_count", elem_count, 336'(k + 1));
            chk("fill_memstate", memory_state, (k == 15) ? 336'd1 : 336'd0);
        end
        elem_valid = 1'b0;
        start      = 1'b0;
    endtask

    initial begin
        n_checks = 0; n_fail = 0; cyc = 0;
        reset = 1'b0; start = 1'b0; abort = 1'b0;
        elem_in = 21'd0; elem_valid = 1'b0;
        step(); step();
        chk("rst_min", Min, 336'd0);
        chk("rst_busy", busy, 336'd0);
        chk("rst_ready", elem_ready, 336'd0);
        chk("rst_memstate", memory_state, 336'd0);
        chk("rst_done", done, 336'd0);
        chk("rst_count", elem_count, 336'd0);
        reset = 1'b1;
        step();

        // Basic fill
        start = 1'b1;
        step();
        start = 1'b0;
        chk("basic_busy", busy, 336'd1);
        chk("basic_ready", elem_ready, 336'd1);
        chk("basic_count0", elem_count, 336'd0);
        run_fill(0, exp_min);
        chk("basic_ready_commit", elem_ready, 336'd0);
        chk("basic_lsb", Min[20:0], 336'd1);
        chk("basic_msb", Min[335:315], 336'd16);
        chk("basic_min", Min, exp_min);
        step();
        chk("basic_done", done, 336'd1);
        chk("basic_busy_done", busy, 336'd0);
        chk("basic_memstate_done", memory_state, 336'd0);
        step();
        chk("basic_done_one", done, 336'd0);
        chk("basic_hold", Min, exp_min);

        // Backpressure: valid toggles, only the last element is all-ones
        start = 1'b1;
        step();
        start = 1'b0;
        acc = 0; pulses = 0;
        for (int c = 0; c < 40 && acc < 16; c++) begin
            elem_valid = (c % 2 == 0) ? 1'b1 : 1'b0;
            elem_in    = elem_valid ? ((acc == 15) ? 21'h1FFFFF : 21'h000000) : 21'h155555;
            step();
            if (elem_valid) acc++;
            chk("bp_count", elem_count, 336'(acc));
            if (memory_state) pulses++;
        end
        elem_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (memory_state) pulses++;
        end
        chk("bp_accepts", 336'(acc), 336'd16);
        chk("bp_pulses", 336'(pulses), 336'd1);
        chk("bp_msb", Min[335:315], 336'h1FFFFF);
        chk("bp_low", Min[314:0], 336'd0);

        // Abort after five accepts, abort together with a valid element
        start = 1'b1;
        step();
        start = 1'b0;
        exp_min = '0;
        for (int k = 0; k < 5; k++) begin
            elem_valid = 1'b1;
            elem_in    = 21'h000100 + 21'(k);
            exp_min[k*21 +: 21] = 21'h000100 + 21'(k);
            step();
        end
        chk("ab_count5", elem_count, 336'd5);
        abort = 1'b1; elem_valid = 1'b1; elem_in = 21'h01ABCD;
        step();
        abort = 1'b0; elem_valid = 1'b0;
        chk("ab_busy", busy, 336'd0);
        chk("ab_count", elem_count, 336'd0);
        chk("ab_ready", elem_ready, 336'd0);
        chk("ab_memstate", memory_state, 336'd0);
        chk("ab_partial", Min, exp_min);
        pulses = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            if (memory_state || done) pulses++;
        end
        chk("ab_nopulse", 336'(pulses), 336'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("ab_restart_min", Min, 336'd0);
        chk("ab_restart_count", elem_count, 336'd0);

        // Ignored controls: start mid-fill, start+abort in COMMIT
        run_fill(1, exp_min);
        start = 1'b1; abort = 1'b1; elem_valid = 1'b1; elem_in = 21'h1ABCDE;
        step();
        start = 1'b0; abort = 1'b0; elem_valid = 1'b0;
        chk("ign_done", done, 336'd1);
        chk("ign_busy", busy, 336'd0);
        chk("ign_min", Min, exp_min);
        step();

        // Back-to-back matrices
        start = 1'b1;
        step();
        start = 1'b0;
        run_fill(2, exp_min);
        t1 = cyc;
        step();
        chk("b2b_done1", done, 336'd1);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("b2b_fill", elem_ready, 336'd1);
        run_fill(3, exp_min);
        chk("b2b_period", 336'(cyc - t1), 336'd18);
        chk("b2b_min", Min, exp_min);
        step();
        chk("b2b_done2", done, 336'd1);

        // Asynchronous reset at element 9
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 9; k++) begin
            elem_valid = 1'b1;
            elem_in    = 21'h0ABC00 + 21'(k);
            step();
        end
        #2 reset = 1'b0;
        #1;
        chk("ar_min", Min, 336'd0);
        chk("ar_busy", busy, 336'd0);
        chk("ar_ready", elem_ready, 336'd0);
        chk("ar_count", elem_count, 336'd0);
        chk("ar_memstate", memory_state, 336'd0);
        chk("ar_done", done, 336'd0);
        elem_valid = 1'b0;
        step(); step();
        reset = 1'b1;
        pulses = 0;
        elem_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            if (memory_state || done || busy) pulses++;
        end
        elem_valid = 1'b0;
        chk("ar_quiet", 336'(pulses), 336'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        run_fill(0, exp_min);
        chk("ar_refill", Min, exp_min);
        step();
        chk("ar_refill_done", done, 336'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/matrix_load_ctrl.md
Name: matrix_load_ctrl

Overview:
Sequencer that fills the 336-bit matrix register (16 elements x 21 bits, 4x4 row-major) from a serial element stream. It accepts elements over a valid/ready handshake and packs them into a staging word. It then issues a single-cycle load command to the matrix memory and signals completion. It sits between the element source (input parser / compute unit) and the matrix memory's Min/memory_state inputs.

Parameters:
ELEM_W, 21, element width in bits
N_ELEM, 16, elements per matrix; ELEM_W*N_ELEM must equal 336
CNT_W, 5, element counter width; must hold N_ELEM

Ports:
CLK  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  begin assembling a new matrix; honoured only in IDLE
abort  input  1  cancel current fill; honoured only in FILL
elem_in  input  21  element data
elem_valid  input  1  elem_in valid this cycle
elem_ready  output  1  controller accepts an element this cycle
Min  output  336  staging word, drives memory Min
memory_state  output  1  memory command: 0 = latch, 1 = load
busy  output  1  state != IDLE
done  output  1  one-cycle pulse; the matrix memory holds the new matrix
elem_count  output  5  elements accepted in the current fill (0..16)

Behaviour:
- Reset applies asynchronously on reset=0 and releases synchronously to CLK. While reset=0: state=IDLE, Min=0, memory_state=0, elem_ready=0, busy=0, done=0, elem_count=0.
- Every output comes from a flop or is a pure decode of the registered state.
- IDLE state:
  - elem_ready=0.
  - If start=1: clear Min to 0, clear elem_count to 0, and move to FILL.
- FILL state:
  - elem_ready=1.
  - Accept occurs when elem_valid & elem_ready.
  - On accept, write elem_in to Min[ELEM_W*k +: ELEM_W], where k=elem_count, then increment elem_count.
  - Element 0 is row 0 col 0, placed at the LSBs. Element 15 is row 3 col 3, at bits [335:315].
  - When the accept makes elem_count=16, move to COMMIT.
  - abort=1 moves to IDLE. The same-cycle element is not accepted, no load is issued, elem_count clears to 0, and Min keeps its partial contents.
  - abort outranks elem_valid.
  - start is ignored.
- COMMIT state:
  - memory_state=1 for exactly one cycle and elem_ready=0.
  - Min is stable and equals the staged matrix.
  - The next state is IDLE unconditionally.
  - start and abort are ignored.
- done:
  - Registered; asserts for one cycle in the cycle after COMMIT, i.e. the first cycle in which the memory output reflects the new matrix.
  - A start in that cycle is honoured, giving back-to-back matrices.
- Min after commit: holds its value until the next accepted start.
- memory_state: 0 in every state except COMMIT.
- Latency at full throughput:
  - start in cycle 0 gives FILL from cycle 1.
  - Accepts occur in cycles 1..16.
  - COMMIT is cycle 17.
  - done is cycle 18.
  - Minimum period per matrix is 18 cycles.
- elem_in is stored unmodified; there is no arithmetic or saturation.
- elem_count never exceeds 16 and never wraps.
- Reset asserted during FILL or COMMIT aborts immediately. No load pulse may appear after reset deasserts.

Test Plan:
- Basic fill: reset, start, then 16 back-to-back elements with value k+1 (k=0..15) -> memory_state=1 in cycle 17 only; Min[20:0]=1, Min[335:315]=16; done in cycle 18; busy low in cycle 18.
- Backpressure: elem_valid toggles 1/0 each cycle, element 15 = 21'h1FFFFF, others 0 -> exactly 16 accepts; Min[335:315]=21'h1FFFFF, Min[314:0]=0; a single load pulse; elem_count steps only on accepts.
- Abort: 5 elements accepted, then abort=1 together with elem_valid=1 -> state IDLE, elem_count=0, no memory_state pulse, no done; a later start clears Min to 0.
- Ignored controls: start pulsed during FILL and COMMIT, and abort during COMMIT -> no effect; the fill completes normally.
- Back-to-back: start asserted in the done cycle, then a second 16-element stream -> second load pulse 18 cycles after the first; Min holds the second matrix.
- Reset mid-operation: reset=0 asynchronously at element 9, then released -> all outputs 0 immediately; no memory_state pulse after release; the next start works normally.
